// File: rtl/count_frame_serializer.sv
// count_frame_serializer: captures {addr, count_in} on a rising edge of the
// sequencer load strobe and shifts it out MSB first as a serial frame
// (ser_clk / ser_data / ser_frame). Receiver samples ser_data on ser_clk rise.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit to the frame.
module count_frame_serializer #(
   parameter int CNT_W   = 16,
   parameter int ADDR_W  = 3,
   parameter int BIT_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [CNT_W-1:0]  count_in,
   input  logic              ovr_clr,
   output logic              ser_clk,
   output logic              ser_data,
   output logic              ser_frame,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

`ifdef SER_PARITY_EN
   localparam int N = ADDR_W + CNT_W + 1;
`else
   localparam int N = ADDR_W + CNT_W;
`endif
   localparam int BCW = (N > 2) ? $clog2(N) : 1;
   localparam int DW  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;

   state_t         state, state_n;
   logic           sl_q;
   logic [N-1:0]   shreg, shreg_n;
   logic [BCW-1:0] bit_cnt, bit_cnt_n;
   logic [DW-1:0]  div_cnt, div_cnt_n;
   logic           ser_clk_n, ser_data_n, ser_frame_n, busy_n, done_n, overrun_n;
   logic           sl_rise;
   logic [N-1:0]   word_ld;

   assign sl_rise = sl & ~sl_q;

   // Frame word as loaded into the shifter; parity bit rides last when enabled
   always_comb begin
`ifdef SER_PARITY_EN
      word_ld = {addr, count_in, ^{addr, count_in}};
`else
      word_ld = {addr, count_in};
`endif
   end

   // State and all registered outputs; everything drops asynchronously on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sl_q      <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         ser_clk   <= 1'b0;
         ser_data  <= 1'b0;
         ser_frame <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         sl_q      <= sl;
         shreg     <= shreg_n;
         bit_cnt   <= bit_cnt_n;
         div_cnt   <= div_cnt_n;
         ser_clk   <= ser_clk_n;
         ser_data  <= ser_data_n;
         ser_frame <= ser_frame_n;
         busy      <= busy_n;
         done      <= done_n;
         overrun   <= overrun_n;
      end
   end

   // Next-state and next-output logic; each half bit lasts BIT_DIV cycles
   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      bit_cnt_n   = bit_cnt;
      div_cnt_n   = div_cnt;
      ser_clk_n   = ser_clk;
      ser_data_n  = ser_data;
      ser_frame_n = ser_frame;
      busy_n      = busy;
      done_n      = 1'b0;
      overrun_n   = overrun;

      case (state)
         IDLE: begin
            if (sl_rise) begin
               state_n     = SHIFT_LO;
               shreg_n     = word_ld;
               bit_cnt_n   = BCW'(N - 1);
               div_cnt_n   = '0;
               ser_frame_n = 1'b1;
               busy_n      = 1'b1;
               ser_clk_n   = 1'b0;
               ser_data_n  = word_ld[N-1];
            end
         end
         SHIFT_LO: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               ser_clk_n = 1'b1;
               state_n   = SHIFT_HI;
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         SHIFT_HI: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               ser_clk_n = 1'b0;
               if (bit_cnt == '0) begin
                  state_n     = DONE;
                  ser_frame_n = 1'b0;
                  ser_data_n  = 1'b0;
                  done_n      = 1'b1;
               end else begin
                  shreg_n    = shreg << 1;
                  ser_data_n = shreg[N-2];
                  bit_cnt_n  = bit_cnt - BCW'(1);
                  state_n    = SHIFT_LO;
               end
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         DONE: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A strobe outside IDLE is dropped but remembered; set beats clear
      if (sl_rise && state != IDLE)
         overrun_n = 1'b1;
      else if (ovr_clr)
         overrun_n = 1'b0;
   end

endmodule

// File: tb/tb_count_frame_serializer.sv
// Directed bench for count_frame_serializer (BIT_DIV=2). A negedge monitor
// rebuilds the serial word from ser_clk rises and counts frame cycles/done pulses.
module tb_count_frame_serializer;

`ifdef SER_PARITY_EN
   localparam int N = 20;
`else
   localparam int N = 19;
`endif
   localparam int FL = 4 * N;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sl = 1'b0;
   logic [2:0]  addr = '0;
   logic [15:0] count_in = '0;
   logic        ovr_clr = 1'b0;
   logic        ser_clk, ser_data, ser_frame, busy, done, overrun;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] mon_bits;
   int          mon_nbits, mon_cyc, mon_done, mon_frames, mon_done_bad;
   logic        clk_prev = 1'b0;
   logic        frame_prev = 1'b0;

   count_frame_serializer #(.CNT_W(16), .ADDR_W(3), .BIT_DIV(2)) dut (
      .clk(clk), .reset(reset), .sl(sl), .addr(addr), .count_in(count_in),
      .ovr_clr(ovr_clr), .ser_clk(ser_clk), .ser_data(ser_data),
      .ser_frame(ser_frame), .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // monitor: sample away from the active edge
   always @(negedge clk) begin
      if (ser_frame) mon_cyc++;
      if (ser_clk && !clk_prev) begin
         mon_bits = {mon_bits[30:0], ser_data};
         mon_nbits++;
      end
      if (ser_frame && !frame_prev) mon_frames++;
      if (done) begin
         mon_done++;
         if (!(frame_prev && !ser_frame)) mon_done_bad++;
      end
      clk_prev   = ser_clk;
      frame_prev = ser_frame;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_bits = '0; mon_nbits = 0; mon_cyc = 0; mon_done = 0;
      mon_frames = 0; mon_done_bad = 0;
   endtask

   task automatic pulse_sl(input logic [2:0] a, input logic [15:0] c);
      addr = a; count_in = c; sl = 1'b1;
      tick(1);
      sl = 1'b0; addr = 3'h7; count_in = 16'hDEAD;
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (busy && g < 400) begin tick(1); g++; end
      if (g >= 400) chk({tag, "_timeout"}, 32'd0, 32'd1);
      tick(2);
   endtask

   task automatic wait_done(input string tag);
      int g = 0;
      while (!done && g < 400) begin tick(1); g++; end
      if (g >= 400) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Hand-computed frame words (MSB first)
`ifdef SER_PARITY_EN
   localparam logic [31:0] W_A5C3 = 32'b101_1010010111000011_0;
   localparam logic [31:0] W_1234 = 32'b010_0001001000110100_0;
   localparam logic [31:0] W_00FF = 32'b011_0000000011111111_0;
   localparam logic [31:0] W_FFFF = 32'b000_1111111111111111_0;
`else
   localparam logic [31:0] W_A5C3 = 32'b101_1010010111000011;
   localparam logic [31:0] W_1234 = 32'b010_0001001000110100;
   localparam logic [31:0] W_00FF = 32'b011_0000000011111111;
   localparam logic [31:0] W_FFFF = 32'b000_1111111111111111;
`endif
   localparam logic [31:0] NMASK = (32'd1 << N) - 32'd1;

   initial begin
      mon_clear();
      // 1: reset state and idle after release
      tick(3);
      chk("rst_outs", {26'd0, ser_clk, ser_data, ser_frame, busy, done, overrun}, 32'd0);
      reset = 1'b0;
      tick(6);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_frames", mon_frames, 32'd0);

      // 2: basic frame
      mon_clear();
      pulse_sl(3'b101, 16'hA5C3);
      chk("basic_busy", {31'd0, busy}, 32'd1);
      wait_idle("basic");
      chk("basic_bits", mon_bits & NMASK, W_A5C3);
      chk("basic_nbits", mon_nbits, N);
      chk("basic_len", mon_cyc, FL);
      chk("basic_done", mon_done, 32'd1);
      chk("basic_done_pos", mon_done_bad, 32'd0);
      chk("basic_ovr", {31'd0, overrun}, 32'd0);

      // 3: overrun 20 cycles into a frame
      mon_clear();
      pulse_sl(3'b010, 16'h1234);
      tick(19);
      addr = 3'b111; count_in = 16'hFFFF; sl = 1'b1;
      tick(1);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      sl = 1'b0;
      wait_idle("ovr");
      chk("ovr_bits", mon_bits & NMASK, W_1234);
      chk("ovr_frames", mon_frames, 32'd1);
      chk("ovr_len", mon_cyc, FL);
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      chk("ovr_clr", {31'd0, overrun}, 32'd0);

      // 4a: strobe held high 200 cycles -> one frame
      mon_clear();
      addr = 3'b011; count_in = 16'h00FF; sl = 1'b1;
      tick(200);
      chk("held_frames", mon_frames, 32'd1);
      chk("held_done", mon_done, 32'd1);
      chk("held_bits", mon_bits & NMASK, W_00FF);
      chk("held_ovr", {31'd0, overrun}, 32'd0);
      sl = 1'b0;
      tick(2);

      // 4b: rise during the DONE cycle -> overrun, no frame
      mon_clear();
      pulse_sl(3'b011, 16'h00FF);
      wait_done("done_rise");
      sl = 1'b1;
      tick(1);
      chk("done_rise_ovr", {31'd0, overrun}, 32'd1);
      sl = 1'b0;
      tick(6);
      chk("done_rise_busy", {31'd0, busy}, 32'd0);
      chk("done_rise_frames", mon_frames, 32'd1);

      // 4c: rise on the first cycle after DONE -> accepted; set beats clear
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      chk("ovr_clr2", {31'd0, overrun}, 32'd0);
      mon_clear();
      pulse_sl(3'b011, 16'h00FF);
      wait_done("b2b");
      tick(1);
      pulse_sl(3'b010, 16'h1234);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      tick(5);
      sl = 1'b1; ovr_clr = 1'b1;
      tick(1);
      sl = 1'b0; ovr_clr = 1'b0;
      chk("set_wins", {31'd0, overrun}, 32'd1);
      wait_idle("b2b");
      chk("b2b_frames", mon_frames, 32'd2);
      chk("b2b_bits", mon_bits & NMASK, W_1234);
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;

      // 5: reset after bit 7, then a clean frame
      mon_clear();
      pulse_sl(3'b101, 16'hA5C3);
      begin
         int g = 0;
         while (mon_nbits < 7 && g < 200) begin tick(1); g++; end
         if (g >= 200) chk("rst_mid_timeout", 32'd0, 32'd1);
      end
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", {26'd0, ser_clk, ser_data, ser_frame, busy, done, overrun}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(4);
      chk("rst_mid_nodone", mon_done, 32'd0);
      mon_clear();
      pulse_sl(3'b000, 16'hFFFF);
      wait_idle("rst_clean");
      chk("rst_clean_bits", mon_bits & NMASK, W_FFFF);
      chk("rst_clean_len", mon_cyc, FL);
      chk("rst_clean_done", mon_done, 32'd1);

`ifdef SER_PARITY_EN
      // 6: parity bit
      mon_clear();
      pulse_sl(3'b001, 16'h0001);
      wait_idle("par0");
      chk("par0_bits", mon_bits & NMASK, 32'b001_0000000000000001_0);
      chk("par0_nbits", mon_nbits, 32'd20);
      mon_clear();
      pulse_sl(3'b001, 16'h0003);
      wait_idle("par1");
      chk("par1_bits", mon_bits & NMASK, 32'b001_0000000000000011_1);
      chk("par1_len", mon_cyc, 32'd80);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
